// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// bin and bcd use ascending ranges so index 0 is the most significant bit.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [0:WIDTH-1]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [0:4*DIGITS-1]   bcd,
  output logic                  ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q;
  logic [WIDTH-1:0]      sr_q, sr_d;
  logic [4*DIGITS-1:0]   work_q, work_d, adj;
  logic                  acc_q, acc_d;
  logic [CW-1:0]         cnt_q;

  // One double-dabble step: digit-wise add-3, then shift {work, sr} left.
  // The bit leaving the top digit is a lost decimal carry, hence overflow.
  always_comb begin
    adj = work_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    {work_d, sr_d} = {adj, sr_q} << 1;
    acc_d = acc_q | adj[4*DIGITS-1];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      work_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr_q    <= bin;
            work_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q   <= sr_d;
          work_q <= work_d;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            bcd     <= work_d;
            ovf     <= acc_d;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations (8/3, 4/2, 8/2) against an
// arithmetic decimal model, with handshake timing, streaming and reset abort.
module tb_bin_to_bcd_seq;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic [7:0] b0 = '0;
  logic [3:0] b1 = '0;
  logic [7:0] b2 = '0;

  logic        bsy [3];
  logic        dn  [3];
  logic        ov  [3];
  logic [11:0] bm  [3];
  logic [11:0] bcd0;
  logic [7:0]  bcd1, bcd2;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned wid [3] = '{8, 4, 8};
  int unsigned dig [3] = '{3, 2, 2};

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u0 (
    .clock(clock), .resetn(resetn), .start(st0), .bin(b0),
    .busy(bsy[0]), .done(dn[0]), .bcd(bcd0), .ovf(ov[0]));
  bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u1 (
    .clock(clock), .resetn(resetn), .start(st1), .bin(b1),
    .busy(bsy[1]), .done(dn[1]), .bcd(bcd1), .ovf(ov[1]));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u2 (
    .clock(clock), .resetn(resetn), .start(st2), .bin(b2),
    .busy(bsy[2]), .done(dn[2]), .bcd(bcd2), .ovf(ov[2]));

  assign bm[0] = bcd0;
  assign bm[1] = {4'h0, bcd1};
  assign bm[2] = {4'h0, bcd2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned pow10(input int unsigned d);
    int unsigned p = 1;
    for (int unsigned i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  // Decimal digits of v modulo 10^d, units digit in the low nibble.
  function automatic logic [11:0] ref_bcd(input int unsigned v, input int unsigned d);
    logic [11:0] r = '0;
    int unsigned x = v;
    for (int unsigned i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic drive(input int unsigned k, input logic s, input int unsigned v);
    case (k)
      0: begin st0 = s; b0 = 8'(v); end
      1: begin st1 = s; b1 = 4'(v); end
      default: begin st2 = s; b2 = 8'(v); end
    endcase
  endtask

  // One full conversion on instance k, checking busy length, done pulse and result.
  task automatic run_conv(input int unsigned k, input int unsigned v);
    int unsigned nbusy = 0;
    logic seen = 1'b0;
    logic [11:0] exp_b;
    exp_b = ref_bcd(v, dig[k]);
    @(negedge clock);
    drive(k, 1'b1, v);
    @(posedge clock);
    #1 drive(k, 1'b0, (v + 5) % (1 << wid[k]));
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (dn[k]) begin
        seen = 1'b1;
        break;
      end
      if (bsy[k]) nbusy++;
    end
    check($sformatf("done_seen[%0d]v%0d", k, v), 32'(seen), 32'd1);
    check($sformatf("busy_len[%0d]v%0d", k, v), nbusy, wid[k]);
    check($sformatf("busy_at_done[%0d]", k), 32'(bsy[k]), 32'd0);
    check($sformatf("bcd[%0d]v%0d", k, v), 32'(bm[k]), 32'(exp_b));
    check($sformatf("ovf[%0d]v%0d", k, v), 32'(ov[k]), 32'(v >= pow10(dig[k])));
    @(negedge clock);
    check($sformatf("done_pulse[%0d]", k), 32'(dn[k]), 32'd0);
    check($sformatf("bcd_hold[%0d]", k), 32'(bm[k]), 32'(exp_b));
  endtask

  initial begin
    int t, t1, t2, ndone;
    repeat (3) @(posedge clock);
    #1;
    for (int unsigned k = 0; k < 3; k++) begin
      check($sformatf("rst_busy[%0d]", k), 32'(bsy[k]), 32'd0);
      check($sformatf("rst_done[%0d]", k), 32'(dn[k]), 32'd0);
      check($sformatf("rst_bcd[%0d]", k), 32'(bm[k]), 32'd0);
      check($sformatf("rst_ovf[%0d]", k), 32'(ov[k]), 32'd0);
    end
    @(negedge clock);
    resetn = 1'b1;

    foreach (wid[k]) begin
      if (k == 0) begin
        run_conv(0, 255); run_conv(0, 0); run_conv(0, 9);
        run_conv(0, 100); run_conv(0, 199);
      end
    end
    for (int unsigned v = 0; v < 256; v++) run_conv(0, v);
    repeat (20) run_conv(0, $urandom_range(255));

    run_conv(1, 13); run_conv(1, 9);
    repeat (10) run_conv(1, $urandom_range(15));

    run_conv(2, 100); run_conv(2, 99); run_conv(2, 255);
    repeat (15) run_conv(2, $urandom_range(255));

    // start held high: results every WIDTH+2 cycles, bin change mid-conversion ignored
    @(negedge clock);
    drive(0, 1'b1, 42);
    t = 0; t1 = -1; t2 = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      t++;
      if (t == 3) b0 = 8'd77;
      if (dn[0]) begin
        if (t1 < 0) begin
          t1 = t;
          check("stream_first", 32'(bm[0]), 32'h042);
        end else begin
          t2 = t;
          check("stream_second", 32'(bm[0]), 32'h077);
          st0 = 1'b0;
          break;
        end
      end
    end
    check("stream_seen", 32'(t2 > 0), 32'd1);
    check("stream_period", 32'(t2 - t1), 32'd10);
    repeat (3) @(negedge clock);
    check("stream_stop", 32'(bsy[0]), 32'd0);

    // reset mid-conversion aborts without publishing
    @(negedge clock);
    drive(0, 1'b1, 200);
    @(posedge clock);
    #1 st0 = 1'b0;
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check("abort_busy", 32'(bsy[0]), 32'd0);
    check("abort_done", 32'(dn[0]), 32'd0);
    check("abort_bcd", 32'(bm[0]), 32'd0);
    ndone = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clock);
      if (dn[0] || bsy[0]) ndone++;
    end
    check("abort_quiet", ndone, 32'd0);
    run_conv(0, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
